// File: rtl/vc_output_port_if.sv
// Bundle of the per-output-port router signals: request/flit bus in, grant back, flit out.
// Latency: none; this is wiring only.
// Backpressure: ro from downstream throttles so; clear tells each input when its flit was taken.
interface vc_output_port_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 4
);
    logic                         polarity;
    logic [NUM_IN-1:0]            req;
    logic [NUM_IN*DATA_WIDTH-1:0] data_in;
    logic [NUM_IN-1:0]            clear;
    logic                         so;
    logic                         ro;
    logic [DATA_WIDTH-1:0]        data_out;
    logic [1:0]                   vc_full;
    logic                         empty;

    // Router side: presents requests and flits, consumes grants and the outgoing flit.
    modport master (
        output polarity, req, data_in, ro,
        input  clear, so, data_out, vc_full, empty
    );

    // Output port side.
    modport slave (
        input  polarity, req, data_in, ro,
        output clear, so, data_out, vc_full, empty
    );
endinterface

// File: rtl/vc_output_port.sv
// Two-VC output port: round-robin accepts flits into VC ~polarity, sends head of VC polarity.
// Latency: a flit granted in cycle n can be sent in cycle n+1 (opposite polarity) if it is the head.
// Backpressure: so is gated by ro; a full accept VC suppresses all grants (clear stays 0).
module vc_output_port #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 4,
    parameter int VC_DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    vc_output_port_if.slave    bus
);
    localparam int PW = $clog2(NUM_IN);
    localparam int AW = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int CW = $clog2(VC_DEPTH + 1);

    logic [PW-1:0]         r_rr  [2];
    logic [AW-1:0]         r_rd  [2];
    logic [AW-1:0]         r_wr  [2];
    logic [CW-1:0]         r_cnt [2];
    logic [DATA_WIDTH-1:0] r_mem [2][VC_DEPTH];

    logic                  w_acc;
    logic                  w_snd;
    logic [1:0]            w_full;
    logic [NUM_IN-1:0]     w_elig;
    logic [PW:0]           w_idx;
    logic                  w_gnt_vld;
    logic [PW-1:0]         w_gnt_idx;
    logic [PW-1:0]         w_rr_nxt;
    logic [NUM_IN-1:0]     w_clear;
    logic [DATA_WIDTH-1:0] w_dat;
    logic                  w_so;

    // Pointer advance that wraps at the buffer depth, which need not be a power of two.
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(VC_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_acc     = ~bus.polarity;
    assign w_snd     = bus.polarity;
    assign w_full[0] = (r_cnt[0] == CW'(VC_DEPTH));
    assign w_full[1] = (r_cnt[1] == CW'(VC_DEPTH));

    // Eligibility: requesting, VC bit matches the accept VC, room in that VC, not in reset.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_elig[i] = reset && !w_full[w_acc] && bus.req[i] &&
                        (bus.data_in[i*DATA_WIDTH + DATA_WIDTH - 1] == w_acc);
        end
    end

    // Round-robin pick starting at the accept VC's pointer, plus the winning flit mux.
    always_comb begin
        w_idx     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_clear   = '0;
        w_dat     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_idx = {1'b0, r_rr[w_acc]} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NUM_IN)) begin
                w_idx = w_idx - (PW+1)'(NUM_IN);
            end
            if (!w_gnt_vld && w_elig[w_idx[PW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx[PW-1:0];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt_vld && (w_gnt_idx == PW'(i))) begin
                w_clear[i] = 1'b1;
                w_dat      = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_rr_nxt     = (w_gnt_idx == PW'(NUM_IN - 1)) ? '0 : w_gnt_idx + PW'(1);
    assign w_so         = (r_cnt[w_snd] != '0) && bus.ro;
    assign bus.so       = w_so;
    assign bus.clear    = w_clear;
    assign bus.data_out = w_so ? r_mem[w_snd][r_rd[w_snd]] : '0;
    assign bus.vc_full  = w_full;
    assign bus.empty    = (r_cnt[0] == '0) && (r_cnt[1] == '0);

    // Per-VC pointers, counts and arbitration pointer; push and pop never hit the same VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                r_rr[v]  <= '0;
                r_rd[v]  <= '0;
                r_wr[v]  <= '0;
                r_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (w_gnt_vld && (w_acc == 1'(v))) begin
                    r_wr[v]  <= f_inc(r_wr[v]);
                    r_rr[v]  <= w_rr_nxt;
                    r_cnt[v] <= r_cnt[v] + CW'(1);
                end else if (w_so && (w_snd == 1'(v))) begin
                    r_rd[v]  <= f_inc(r_rd[v]);
                    r_cnt[v] <= r_cnt[v] - CW'(1);
                end
            end
        end
    end

    // Flit storage; contents are only visible through the counts, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_gnt_vld) begin
            r_mem[w_acc][r_wr[w_acc]] <= w_dat;
        end
    end
endmodule

// File: tb/tb_vc_output_port.sv
module tb_vc_output_port;
    localparam int DW = 64;
    localparam int N  = 4;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_output_port_if #(.DATA_WIDTH(DW), .NUM_IN(N)) bus ();

    vc_output_port #(.DATA_WIDTH(DW), .NUM_IN(N), .VC_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one queue per VC plus one round-robin pointer per VC.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int rr[2];
    logic [DW-1:0] din[N];
    logic [N-1:0] last_clear;
    logic [DW-1:0] last_dout;
    logic last_so;

    function automatic int qs(int v);
        return (v == 1) ? q1.size() : q0.size();
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        rr[0] = 0;
        rr[1] = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the model, advance model.
    task automatic step(logic pol, logic [N-1:0] rq, logic ro_v);
        int acc;
        int snd;
        int gi;
        logic exp_so;
        logic [DW-1:0] exp_dout;
        logic [N-1:0] exp_clear;
        bus.polarity = pol;
        bus.req = rq;
        bus.ro = ro_v;
        for (int i = 0; i < N; i++) bus.data_in[i*DW +: DW] = din[i];
        @(negedge clk);
        acc = pol ? 0 : 1;
        snd = pol ? 1 : 0;
        gi = -1;
        if (reset && qs(acc) < D) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (rr[acc] + k) % N;
                if (gi < 0 && rq[i] && (din[i][DW-1] == (acc == 1))) gi = i;
            end
        end
        exp_clear = '0;
        if (gi >= 0) exp_clear[gi] = 1'b1;
        exp_so = reset && ro_v && (qs(snd) > 0);
        exp_dout = '0;
        if (exp_so) exp_dout = (snd == 1) ? q1[0] : q0[0];
        chk("clear", DW'(bus.clear), DW'(exp_clear));
        chk("so", DW'(bus.so), DW'(exp_so));
        chk("data_out", bus.data_out, exp_dout);
        chk("vc_full", DW'(bus.vc_full), DW'({qs(1) == D, qs(0) == D}));
        chk("empty", DW'(bus.empty), DW'(qs(0) == 0 && qs(1) == 0));
        last_clear = bus.clear;
        last_dout = bus.data_out;
        last_so = bus.so;
        @(posedge clk);
        if (reset) begin
            if (gi >= 0) begin
                if (acc == 1) q1.push_back(din[gi]);
                else q0.push_back(din[gi]);
                rr[acc] = (gi + 1) % N;
            end
            if (exp_so) begin
                if (snd == 1) void'(q1.pop_front());
                else void'(q0.pop_front());
            end
        end
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle, held for two edges, then released.
    task automatic mid_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_so", DW'(bus.so), DW'(0));
        chk("rst_dout", bus.data_out, DW'(0));
        chk("rst_empty", DW'(bus.empty), DW'(1));
        chk("rst_full", DW'(bus.vc_full), DW'(0));
        chk("rst_clear", DW'(bus.clear), DW'(0));
        step(1'b0, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        reset = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_flit(logic vc);
        logic [DW-1:0] f;
        f = {$urandom(), $urandom()};
        f[DW-1] = vc;
        return f;
    endfunction

    initial begin
        model_reset();
        bus.polarity = 1'b0;
        bus.req = '0;
        bus.ro = 1'b0;
        bus.data_in = '0;
        for (int i = 0; i < N; i++) din[i] = '0;
        #12;
        // Reset state with requests pending: nothing may be granted or sent.
        bus.req = 4'b1111;
        bus.ro = 1'b1;
        #1;
        chk("reset_so", DW'(bus.so), DW'(0));
        chk("reset_clear", DW'(bus.clear), DW'(0));
        chk("reset_empty", DW'(bus.empty), DW'(1));
        chk("reset_full", DW'(bus.vc_full), DW'(0));
        chk("reset_dout", bus.data_out, DW'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Single flit through VC1.
        din[0] = 64'h8000_0000_0000_00AA;
        step(1'b0, 4'b0001, 1'b1);
        chk("single_clear", DW'(last_clear), DW'(4'b0001));
        step(1'b1, 4'b0000, 1'b1);
        chk("single_so", DW'(last_so), DW'(1));
        chk("single_dout", last_dout, 64'h8000_0000_0000_00AA);
        step(1'b0, 4'b0000, 1'b1);
        chk("single_empty", DW'(bus.empty), DW'(1));

        // Round robin into VC1 with downstream stalled until full.
        mid_reset();
        for (int i = 0; i < N; i++) din[i] = rnd_flit(1'b1);
        step(1'b0, 4'b1111, 1'b0);
        chk("rr_g0", DW'(last_clear), DW'(4'b0001));
        step(1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        chk("rr_g1", DW'(last_clear), DW'(4'b0010));
        chk("rr_full", DW'(bus.vc_full), DW'(2'b10));
        for (int c = 0; c < 4; c++) step(1'(c[0]), 4'b1111, 1'b0);
        for (int c = 0; c < 4; c++) step(1'(~c[0]), 4'b0000, 1'b1);

        // Pointer wrap: move VC1 pointer to 3, then 1001 grants 3 and later 0.
        mid_reset();
        for (int i = 0; i < N; i++) din[i] = rnd_flit(1'b1);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b1001, 1'b1);
        chk("wrap_g3", DW'(last_clear), DW'(4'b1000));
        step(1'b1, 4'b1001, 1'b1);
        step(1'b0, 4'b1001, 1'b1);
        chk("wrap_g0", DW'(last_clear), DW'(4'b0001));
        step(1'b1, 4'b0000, 1'b1);

        // Backpressure on VC0 holding two flits.
        for (int i = 0; i < N; i++) din[i] = rnd_flit(1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        for (int c = 0; c < 4; c++) step(1'(c[0]), 4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) step(1'(c[0]), 4'b0000, 1'b1);

        // Wrong-phase request is held off until its accept phase.
        din[1] = rnd_flit(1'b1);
        step(1'b1, 4'b0010, 1'b1);
        chk("wrong_phase", DW'(last_clear), DW'(0));
        step(1'b0, 4'b0010, 1'b1);
        chk("right_phase", DW'(last_clear), DW'(4'b0010));
        step(1'b1, 4'b0000, 1'b1);

        // Fill both VCs then reset mid-operation; nothing may come out afterwards.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) din[i] = rnd_flit(1'(~c[0]));
            step(1'(c[0]), 4'b1111, 1'b0);
        end
        chk("both_full", DW'(bus.vc_full), DW'(2'b11));
        mid_reset();
        for (int c = 0; c < 4; c++) step(1'(c[0]), 4'b0000, 1'b1);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            logic pol;
            pol = ($urandom_range(0, 9) == 0) ? 1'($urandom()) : 1'(c[0]);
            for (int i = 0; i < N; i++) din[i] = rnd_flit(1'($urandom()));
            step(pol, N'($urandom()), ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 149) == 0) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vc_output_port.md
VC_OUTPUT_PORT -- requirements
Module: vc_output_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the flit width; bit DATA_WIDTH-1 is the VC bit.
REQ-002 The block SHALL have parameter NUM_IN, default 4, giving the number of requesting input ports (range 2..8).
REQ-003 The block SHALL have parameter VC_DEPTH, default 2, giving the entries per virtual-channel buffer (range 1..8).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 polarity  input  1  router-level cycle parity.
REQ-007 req  input  NUM_IN  bit i set = input i holds a flit for this output.
REQ-008 data_in  input  NUM_IN*DATA_WIDTH  flit of input i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 clear  output  NUM_IN  one-hot grant; bit i set = input i's flit is accepted at this edge.
REQ-010 so  output  1  send-out valid toward the downstream router.
REQ-011 ro  input  1  downstream ready.
REQ-012 data_out  output  DATA_WIDTH  flit to downstream.
REQ-013 vc_full  output  2  per-VC buffer full flags.
REQ-014 empty  output  1  set when both VC buffers are empty.

Function
REQ-015 The block SHALL hold two independent FIFOs, VC0 and VC1, each VC_DEPTH deep, each with a read pointer, a write pointer and an occupancy count of 0..VC_DEPTH.
REQ-016 Phase rule: when polarity=p, VC p is the external (send) VC and VC ~p is the internal (accept) VC; a single VC is never pushed and popped in the same cycle.
REQ-017 Eligible set = {i : req[i]=1 and data_in slice i bit DATA_WIDTH-1 = ~polarity}; if the accept VC is full, the eligible set is empty.
REQ-018 Arbitration: each VC has its own round-robin pointer; the grant goes to the first eligible index at or after that pointer, wrapping modulo NUM_IN.
REQ-019 clear SHALL be combinational and one-hot or zero; on the edge where clear[i]=1, slice i is written into the accept VC, the write pointer wraps modulo VC_DEPTH, the count increments, and that VC's pointer moves to (i+1) mod NUM_IN.
REQ-020 When there is no grant, that VC's round-robin pointer SHALL hold its value.
REQ-021 so SHALL equal (count of VC polarity > 0) AND ro, combinationally.
REQ-022 data_out SHALL equal the head of VC polarity when so=1, and all zeros otherwise.
REQ-023 On an edge with so=1, the head SHALL be popped: the read pointer wraps and the count decrements.
REQ-024 Latency: a flit granted in cycle n (polarity=~v) is offered in cycle n+1 (polarity=v) when it is the head and ro=1.
REQ-025 FIFO order SHALL be preserved within each VC; there is no ordering between VCs.
REQ-026 vc_full[v] SHALL equal (count_v == VC_DEPTH); empty SHALL equal (count_0 == 0 AND count_1 == 0); both are combinational from the registered counts.
REQ-027 Requests whose VC bit equals polarity SHALL be ignored in that cycle and never granted in it.
REQ-028 Flit contents SHALL NOT be modified.

Reset
REQ-029 While reset=0, the block SHALL asynchronously clear all pointers, counts and round-robin pointers (to input 0), discarding any buffered flits.
REQ-030 Output values during reset: so=0, data_out=0, clear=0, vc_full=2'b00, empty=1.
REQ-031 Reset release SHALL take effect synchronously at the first clk edge with reset=1; reset asserted mid-operation drops all flits without any so pulse.

Verification (NUM_IN=4, VC_DEPTH=2, DATA_WIDTH=64)
REQ-032 Single flit: after reset, polarity=0, req=0001, data_in[0]=0x8000_0000_0000_00AA, ro=1 -> clear=0001; next cycle (polarity=1) so=1, data_out=0x8000_0000_0000_00AA; cycle after that empty=1.
REQ-033 Round robin: req=1111 with all flits VC1, ro=0, polarity toggling -> grants on even cycles go to inputs 0 then 1; vc_full[1]=1 after the second grant; no clear while full.
REQ-034 Wrap/fairness: VC1 pointer at 3, req=1001 -> grant to input 3, then to input 0 on the next accept phase.
REQ-035 Backpressure: VC0 holding 2 flits, ro=0 for 4 cycles -> so stays 0 and data_out=0; ro=1 -> both flits leave in order on consecutive polarity=0 cycles.
REQ-036 Wrong-phase request: polarity=1, req=0010 with VC bit=1 -> clear=0000; granted on the following polarity=0 cycle.
REQ-037 Mid-operation reset: both VCs full, reset=0 asynchronously -> so=0, empty=1, vc_full=00 immediately, and no flit appears after release.
